// File: rtl/resp_checker_if.sv
// resp_checker_if
//  Bundles the sweep-observation signals between a stimulus/DUT side and the
//  response checker.
//  master : drives start, vec_in, m_in; observes the checker results
//  slave  : the checker itself
//  Signals:
//   start          arm pulse for one sweep
//   vec_in, m_in   vector applied to the DUT and its 1-bit response
//   busy           sweep in progress
//   sample_stb     sampling-cycle pulse
//   done           end-of-sweep pulse
//   pass           last sweep was error-free
//   err_count      mismatched vectors in last/current sweep
//   first_err_vec  index of the first mismatching vector
//   first_err_vld  first_err_vec holds a captured index
interface resp_checker_if #(
   parameter int N_IN = 3
);
   logic            start;
   logic [N_IN-1:0] vec_in;
   logic            m_in;
   logic            busy;
   logic            sample_stb;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_vec;
   logic            first_err_vld;

   modport master (
      output start, vec_in, m_in,
      input  busy, sample_stb, done, pass, err_count, first_err_vec, first_err_vld
   );

   modport slave (
      input  start, vec_in, m_in,
      output busy, sample_stb, done, pass, err_count, first_err_vec, first_err_vld
   );
endinterface

// File: rtl/resp_checker.sv
// resp_checker
//  Receive end of an exhaustive-sweep bench. Follows a generator that holds each
//  of the 2**N_IN vectors for HOLD cycles, samples the applied vector and the DUT
//  response once per window, and compares them against the EXPECT truth table.
//  Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, aborts any sweep in progress
//   bus   resp_checker_if.slave (start/vec_in/m_in in, results out)
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for start; results from the last sweep are held
//  S_RUN  | counting HOLD-cycle windows, sampling at the end of each
//  S_FIN  | one-cycle done pulse; pass is latched from the final count
module resp_checker #(
   parameter int                  N_IN   = 3,
   parameter logic [2**N_IN-1:0]  EXPECT = 8'b1110_1000,
   parameter int                  HOLD   = 25
) (
   input logic           clk,
   input logic           rst,
   resp_checker_if.slave bus
);
   localparam int              CW       = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
   localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic [N_IN-1:0] idx;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] first_err_vec;
   logic            first_err_vld;
   logic            pass;
   logic            busy, done, sample_stb;
   logic            mismatch;

   // Sequence and value errors on the same vector count as a single mismatch.
   assign mismatch = (bus.vec_in != idx) || (bus.m_in != EXPECT[idx]);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (bus.start) state_nx = S_RUN;
         S_RUN:   if (sample_stb && (idx == IDX_LAST)) state_nx = S_FIN;
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      sample_stb = 1'b0;
      case (state)
         S_RUN: begin
            busy       = 1'b1;
            sample_stb = (cnt == CNT_LAST);
         end
         S_FIN:   done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         idx           <= '0;
         err_count     <= '0;
         first_err_vec <= '0;
         first_err_vld <= 1'b0;
         pass          <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  cnt           <= '0;
                  idx           <= '0;
                  err_count     <= '0;
                  first_err_vec <= '0;
                  first_err_vld <= 1'b0;
                  pass          <= 1'b0;
               end
            end
            S_RUN: begin
               if (sample_stb) begin
                  cnt <= '0;
                  if (mismatch) begin
                     err_count <= err_count + (N_IN+1)'(1);
                     if (!first_err_vld) begin
                        first_err_vec <= idx;
                        first_err_vld <= 1'b1;
                     end
                  end
                  if (idx != IDX_LAST) idx <= idx + N_IN'(1);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_FIN:   pass <= (err_count == '0);
            default: ;
         endcase
      end
   end

   assign bus.busy          = busy;
   assign bus.done          = done;
   assign bus.sample_stb    = sample_stb;
   assign bus.pass          = pass;
   assign bus.err_count     = err_count;
   assign bus.first_err_vec = first_err_vec;
   assign bus.first_err_vld = first_err_vld;
endmodule
